// File: rtl/idct4x4_sched.sv
// ---------------------------------------------------------------------------
// idct4_core / idct4x4_sched
//
// idct4_core: 1-D 4-point inverse DCT (64/83/36 butterfly). The operands
//   presented with load=1 in cycle n produce results on y0..y3 in cycle n+2.
//   The core carries no valid flag; its user has to track the latency.
//   Ports: clk, load, x0..x3 (WX signed in), y0..y3 (WY signed out).
//
// idct4x4_sched: drives one shared idct4_core through a 2-D 4x4 inverse
//   transform. The row pass sends the four input rows through the core into
//   a transpose buffer (tbuf). The column pass sends the tbuf columns through
//   the same core into an output buffer (obuf). obuf then drains as four rows
//   on a valid/ready stream.
//   Ports:
//     clk, rst (synchronous, active low)
//     in_valid/in_ready, in_row0..3     : input coefficient rows (WX signed)
//     core_load, core_x0..3, core_y0..3 : shared IDCT core interface
//     out_valid/out_ready, out_row0..3  : residual rows (OUT_W signed)
//     busy     : high except when idle in ROW with no row taken yet
//     blk_done : one-cycle pulse on the last output handshake of a block
//   Build option: define IDCT4_ROUND_EN to add the round-half-up offsets
//   before both right shifts. Without it, both shifts are plain floor shifts.
// ---------------------------------------------------------------------------
module idct4_core #(
  parameter int WX = 16,
  parameter int WY = 22
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic signed [WX-1:0] x0,
  input  logic signed [WX-1:0] x1,
  input  logic signed [WX-1:0] x2,
  input  logic signed [WX-1:0] x3,
  output logic signed [WY-1:0] y0,
  output logic signed [WY-1:0] y1,
  output logic signed [WY-1:0] y2,
  output logic signed [WY-1:0] y3
);
  logic signed [WY-1:0] e0_reg, e1_reg, o0_reg, o1_reg;

  // Stage 1: even/odd partial sums. Stage 2: output butterfly.
  always_ff @(posedge clk) begin
    if (load) begin
      e0_reg <= WY'(64 * x0 + 64 * x2);
      e1_reg <= WY'(64 * x0 - 64 * x2);
      o0_reg <= WY'(83 * x1 + 36 * x3);
      o1_reg <= WY'(36 * x1 - 83 * x3);
    end
    y0 <= e0_reg + o0_reg;
    y1 <= e1_reg + o1_reg;
    y2 <= e1_reg - o1_reg;
    y3 <= e0_reg - o0_reg;
  end
endmodule

module idct4x4_sched #(
  parameter int WX     = 16,
  parameter int WY     = 22,
  parameter int SHIFT1 = 7,
  parameter int SHIFT2 = 12,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WX-1:0]    in_row0,
  input  logic signed [WX-1:0]    in_row1,
  input  logic signed [WX-1:0]    in_row2,
  input  logic signed [WX-1:0]    in_row3,
  output logic                    core_load,
  output logic signed [WX-1:0]    core_x0,
  output logic signed [WX-1:0]    core_x1,
  output logic signed [WX-1:0]    core_x2,
  output logic signed [WX-1:0]    core_x3,
  input  logic signed [WY-1:0]    core_y0,
  input  logic signed [WY-1:0]    core_y1,
  input  logic signed [WY-1:0]    core_y2,
  input  logic signed [WY-1:0]    core_y3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_row0,
  output logic signed [OUT_W-1:0] out_row1,
  output logic signed [OUT_W-1:0] out_row2,
  output logic signed [OUT_W-1:0] out_row3,
  output logic                    busy,
  output logic                    blk_done
);
  typedef enum logic [2:0] {ROW, ROW_DRAIN, COL, COL_DRAIN, OUT} state_t;

  state_t     state_reg;
  logic [1:0] rcnt_reg, ccnt_reg, ocnt_reg;
  logic       dcnt_reg;

  // Issue tag pipeline, aligned with the 2-cycle core latency. p2 describes
  // the result that is on core_y in the current cycle.
  logic       p1_vld_reg, p1_col_reg, p2_vld_reg, p2_col_reg;
  logic [1:0] p1_idx_reg, p2_idx_reg;

  logic signed [WX-1:0]    tbuf [4][4];
  logic signed [OUT_W-1:0] obuf [4][4];

  logic signed [WX-1:0]    in_row [4];
  logic signed [WX-1:0]    core_x [4];
  logic signed [WY-1:0]    core_y [4];
  logic signed [WX-1:0]    st1    [4];
  logic signed [OUT_W-1:0] st2    [4];
  logic                    in_hs, out_hs;

  assign in_row[0] = in_row0;
  assign in_row[1] = in_row1;
  assign in_row[2] = in_row2;
  assign in_row[3] = in_row3;
  assign core_y[0] = core_y0;
  assign core_y[1] = core_y1;
  assign core_y[2] = core_y2;
  assign core_y[3] = core_y3;
  assign core_x0   = core_x[0];
  assign core_x1   = core_x[1];
  assign core_x2   = core_x[2];
  assign core_x3   = core_x[3];

  assign in_ready  = (state_reg == ROW);
  assign out_valid = (state_reg == OUT);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign core_load = in_hs || (state_reg == COL);
  assign busy      = !((state_reg == ROW) && (rcnt_reg == 2'd0));
  assign blk_done  = out_hs && (ocnt_reg == 2'd3);

  // Row pass feeds the input straight through. Column pass reads a tbuf column.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      core_x[j] = '0;
      if (in_hs)
        core_x[j] = in_row[j];
      else if (state_reg == COL)
        core_x[j] = tbuf[j][ccnt_reg];
    end
  end

  assign out_row0 = out_valid ? obuf[ocnt_reg][0] : '0;
  assign out_row1 = out_valid ? obuf[ocnt_reg][1] : '0;
  assign out_row2 = out_valid ? obuf[ocnt_reg][2] : '0;
  assign out_row3 = out_valid ? obuf[ocnt_reg][3] : '0;

`ifdef IDCT4_ROUND_EN
  localparam logic signed [WY:0] RND1 = (WY+1)'(1) << (SHIFT1 - 1);
  localparam logic signed [WY:0] RND2 = (WY+1)'(1) << (SHIFT2 - 1);
`endif

  // Per-lane scaling. One guard bit keeps the rounding add from wrapping.
  // The arithmetic shift floors before truncation.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic signed [WY:0] y_ext, sum1, sum2;
    assign y_ext = {core_y[gi][WY-1], core_y[gi]};
`ifdef IDCT4_ROUND_EN
    assign sum1 = y_ext + RND1;
    assign sum2 = y_ext + RND2;
`else
    assign sum1 = y_ext;
    assign sum2 = y_ext;
`endif
    assign st1[gi] = WX'(sum1 >>> SHIFT1);
    assign st2[gi] = OUT_W'(sum2 >>> SHIFT2);
  end

  // Result capture. Reset kills the tags, so in-flight results are dropped.
  always_ff @(posedge clk) begin
    if (rst && p2_vld_reg) begin
      for (int j = 0; j < 4; j++) begin
        if (p2_col_reg)
          obuf[j][p2_idx_reg] <= st2[j];
        else
          tbuf[p2_idx_reg][j] <= st1[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ROW;
      rcnt_reg   <= 2'd0;
      ccnt_reg   <= 2'd0;
      ocnt_reg   <= 2'd0;
      dcnt_reg   <= 1'b0;
      p1_vld_reg <= 1'b0;
      p1_col_reg <= 1'b0;
      p1_idx_reg <= 2'd0;
      p2_vld_reg <= 1'b0;
      p2_col_reg <= 1'b0;
      p2_idx_reg <= 2'd0;
    end else begin
      p1_vld_reg <= core_load;
      p1_col_reg <= (state_reg == COL);
      p1_idx_reg <= (state_reg == COL) ? ccnt_reg : rcnt_reg;
      p2_vld_reg <= p1_vld_reg;
      p2_col_reg <= p1_col_reg;
      p2_idx_reg <= p1_idx_reg;
      case (state_reg)
        ROW: begin
          if (in_hs) begin
            rcnt_reg <= rcnt_reg + 2'd1;
            if (rcnt_reg == 2'd3) state_reg <= ROW_DRAIN;
          end
        end
        ROW_DRAIN: begin
          dcnt_reg <= ~dcnt_reg;
          if (dcnt_reg) state_reg <= COL;
        end
        COL: begin
          ccnt_reg <= ccnt_reg + 2'd1;
          if (ccnt_reg == 2'd3) state_reg <= COL_DRAIN;
        end
        COL_DRAIN: begin
          dcnt_reg <= ~dcnt_reg;
          if (dcnt_reg) state_reg <= OUT;
        end
        OUT: begin
          if (out_hs) begin
            ocnt_reg <= ocnt_reg + 2'd1;
            if (ocnt_reg == 2'd3) state_reg <= ROW;
          end
        end
        default: state_reg <= ROW;
      endcase
    end
  end
endmodule

// File: tb/tb_idct4x4_sched.sv
// ---------------------------------------------------------------------------
// tb_idct4x4_sched: directed bench for idct4x4_sched together with the real
// idct4_core. Expected residuals were worked out by hand for both settings
// of IDCT4_ROUND_EN.
// ---------------------------------------------------------------------------
module tb_idct4x4_sched;
  localparam int WX = 16, WY = 22, OW = 16;

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [WX-1:0] in_row0 = '0, in_row1 = '0, in_row2 = '0, in_row3 = '0;
  logic in_ready, core_load, out_valid, busy, blk_done;
  logic signed [WX-1:0] core_x0, core_x1, core_x2, core_x3;
  logic signed [WY-1:0] core_y0, core_y1, core_y2, core_y3;
  logic signed [OW-1:0] out_row0, out_row1, out_row2, out_row3;

  always #5 clk = ~clk;

  idct4_core #(.WX(WX), .WY(WY)) u_core (
    .clk(clk), .load(core_load),
    .x0(core_x0), .x1(core_x1), .x2(core_x2), .x3(core_x3),
    .y0(core_y0), .y1(core_y1), .y2(core_y2), .y3(core_y3)
  );

  idct4x4_sched #(.WX(WX), .WY(WY), .SHIFT1(7), .SHIFT2(12), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_row0(in_row0), .in_row1(in_row1), .in_row2(in_row2), .in_row3(in_row3),
    .core_load(core_load),
    .core_x0(core_x0), .core_x1(core_x1), .core_x2(core_x2), .core_x3(core_x3),
    .core_y0(core_y0), .core_y1(core_y1), .core_y2(core_y2), .core_y3(core_y3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row0(out_row0), .out_row1(out_row1), .out_row2(out_row2), .out_row3(out_row3),
    .busy(busy), .blk_done(blk_done)
  );

  int n_checks = 0, n_pass = 0;
  logic [63:0] stim [$];
  logic [63:0] outq [$];
  int hs_q [$], ovr_q [$], blk_q [$];
  int cyc = 0, ir_low = 0, cl_total = 0, cl_bad = 0;
  bit prev_ov = 1'b0;

  // Expected values for both rounding modes.
`ifdef IDCT4_ROUND_EN
  localparam int DCV = 1, NEGV = 0;
  localparam int V3 [4][4] = '{'{2, 2, 2, 1}, '{2, 1, 1, 0}, '{1, 0, 0, -1}, '{0, -1, -1, -1}};
`else
  localparam int DCV = 0, NEGV = -1;
  localparam int V3 [4][4] = '{'{2, 2, 1, 1}, '{1, 1, 0, 0}, '{0, 0, -1, -1}, '{-1, -1, -2, -2}};
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mkrow(input int a, input int b, input int c, input int d);
    return {a[15:0], b[15:0], c[15:0], d[15:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    outq.delete(); hs_q.delete(); ovr_q.delete(); blk_q.delete();
    ir_low = 0; cl_total = 0; cl_bad = 0;
  endtask

  // Monitor: samples on the falling edge, one print per transaction.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      if (in_valid && in_ready) begin
        hs_q.push_back(cyc);
        $display("in  row: %0d %0d %0d %0d @%0d", in_row0, in_row1, in_row2, in_row3, cyc);
      end
      if (!in_ready) ir_low++;
      if (core_load) begin
        cl_total++;
        if (in_ready && !in_valid) cl_bad++;
      end
      if (out_valid && !prev_ov) ovr_q.push_back(cyc);
      if (out_valid && out_ready) begin
        outq.push_back({out_row0, out_row1, out_row2, out_row3});
        $display("out row: %0d %0d %0d %0d @%0d", out_row0, out_row1, out_row2, out_row3, cyc);
      end
      if (blk_done) blk_q.push_back(cyc);
    end
    prev_ov = out_valid;
  end

  task automatic send_rows(input int n, input bit sparse);
    int i = 0, guard = 0;
    bit ph = 1'b0, hs;
    while (i < n && guard < 500) begin
      in_valid = sparse ? ph : 1'b1;
      ph = ~ph;
      {in_row0, in_row1, in_row2, in_row3} = stim[i];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
    {in_row0, in_row1, in_row2, in_row3} = '0;
    stim.delete();
    check("rows_sent", 64'(i), 64'(n));
  endtask

  task automatic wait_out(input int n);
    int g = 0;
    while (outq.size() < n && g < 300) begin
      tick(1);
      g++;
    end
    check($sformatf("out_count%0d", n), 64'(outq.size()), 64'(n));
  endtask

  task automatic cmp_rows(input string tag, input int base,
                          input logic [63:0] e0, input logic [63:0] e1,
                          input logic [63:0] e2, input logic [63:0] e3);
    logic [63:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_row%0d", tag, k),
            (outq.size() > base + k) ? outq[base + k] : 64'hx, e[k]);
  endtask

  task automatic push_block(input int r0c0, input int r0c1, input int r1c0);
    stim.push_back(mkrow(r0c0, r0c1, 0, 0));
    stim.push_back(mkrow(r1c0, 0, 0, 0));
    stim.push_back(mkrow(0, 0, 0, 0));
    stim.push_back(mkrow(0, 0, 0, 0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] dc_row, held, cur;
    int bad_v, bad_s, bad_ir, bad_bd;
    dc_row = mkrow(DCV, DCV, DCV, DCV);

    // Reset state.
    rst = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_ctrl", 64'({out_valid, core_load, blk_done, busy}), 64'(0));
    check("rst_core_x", {core_x0, core_x1, core_x2, core_x3}, 64'(0));
    check("rst_out_row", {out_row0, out_row1, out_row2, out_row3}, 64'(0));
    tick(1);
    rst = 1'b1;
    tick(1);

    // Two DC blocks back to back, in_valid and out_ready held high.
    clear_mon();
    out_ready = 1'b1;
    push_block(64, 0, 0);
    push_block(64, 0, 0);
    send_rows(8, 1'b0);
    wait_out(8);
    tick(2);
    cmp_rows("dc_a", 0, dc_row, dc_row, dc_row, dc_row);
    cmp_rows("dc_b", 4, dc_row, dc_row, dc_row, dc_row);
    check("tm_blk_cnt", 64'(blk_q.size()), 64'(2));
    check("tm_blk_period", 64'((blk_q.size() >= 2) ? blk_q[1] - blk_q[0] : -1), 64'(16));
    check("tm_in_period", 64'((hs_q.size() >= 5) ? hs_q[4] - hs_q[0] : -1), 64'(16));
    check("tm_in_gap", 64'((hs_q.size() >= 5) ? hs_q[4] - hs_q[3] : -1), 64'(13));
    check("tm_ir_low", 64'(ir_low), 64'(24));
    // Eight idle cycles lie between the 4th input handshake and the first out_valid.
    check("tm_first_ov_gap",
          64'((hs_q.size() >= 4 && ovr_q.size() >= 1) ? ovr_q[0] - hs_q[3] - 1 : -1), 64'(8));

    // Asymmetric block with a 5-cycle stall on the 2nd output row.
    clear_mon();
    push_block(64, 64, 128);
    send_rows(4, 1'b0);
    wait_out(1);
    out_ready = 1'b0;
    bad_v = 0; bad_s = 0; bad_ir = 0; bad_bd = 0; held = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cur = {out_row0, out_row1, out_row2, out_row3};
      if (k == 0) held = cur;
      bad_v += int'(!out_valid);
      bad_s += int'(cur !== held);
      bad_ir += int'(in_ready);
      bad_bd += int'(blk_done);
      @(posedge clk);
      #1;
    end
    check("bp_out_valid_drop", 64'(bad_v), 64'(0));
    check("bp_row_unstable", 64'(bad_s), 64'(0));
    check("bp_in_ready_high", 64'(bad_ir), 64'(0));
    check("bp_blk_done", 64'(bad_bd), 64'(0));
    check("bp_held_row", held, mkrow(V3[1][0], V3[1][1], V3[1][2], V3[1][3]));
    out_ready = 1'b1;
    wait_out(4);
    tick(2);
    cmp_rows("v3", 0, mkrow(V3[0][0], V3[0][1], V3[0][2], V3[0][3]),
                      mkrow(V3[1][0], V3[1][1], V3[1][2], V3[1][3]),
                      mkrow(V3[2][0], V3[2][1], V3[2][2], V3[2][3]),
                      mkrow(V3[3][0], V3[3][1], V3[3][2], V3[3][3]));
    check("bp_blk_cnt", 64'(blk_q.size()), 64'(1));

    // Sparse input: in_valid toggles every cycle.
    clear_mon();
    push_block(64, 0, 0);
    send_rows(4, 1'b1);
    wait_out(4);
    tick(2);
    cmp_rows("sparse", 0, dc_row, dc_row, dc_row, dc_row);
    check("sp_load_total", 64'(cl_total), 64'(8));
    check("sp_load_idle", 64'(cl_bad), 64'(0));
    check("sp_in_hs", 64'(hs_q.size()), 64'(4));

    // Reset during the column pass.
    clear_mon();
    push_block(64, 0, 0);
    send_rows(4, 1'b0);
    tick(2);
    @(negedge clk);
    check("col_load", 64'(core_load), 64'(1));
    check("col_x0_tbuf", 64'(core_x0), 64'(32));
    check("col_x123", 64'({core_x1, core_x2, core_x3}), 64'(0));
    check("col_busy", 64'(busy), 64'(1));
    tick(1);
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    check("abort_ctrl", 64'({out_valid, core_load, busy}), 64'(0));
    tick(1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'(1));
    tick(20);
    check("abort_no_out", 64'(outq.size()), 64'(0));
    check("abort_no_done", 64'(blk_q.size()), 64'(0));
    clear_mon();
    push_block(0, 0, 0);
    send_rows(4, 1'b0);
    wait_out(4);
    cmp_rows("zero", 0, 64'(0), 64'(0), 64'(0), 64'(0));

    // Negative DC.
    clear_mon();
    push_block(-64, 0, 0);
    send_rows(4, 1'b0);
    wait_out(4);
    cmp_rows("neg", 0, mkrow(NEGV, NEGV, NEGV, NEGV), mkrow(NEGV, NEGV, NEGV, NEGV),
                       mkrow(NEGV, NEGV, NEGV, NEGV), mkrow(NEGV, NEGV, NEGV, NEGV));

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
